// File: rtl/regfile_sequencer.sv
// Command sequencer for a two-read/one-write register file. Each accepted command
// goes through read, execute, optional write-back and then a response handshake.
module regfile_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_RD  = 3'b111;

  logic [2:0]        state_reg;
  logic [2:0]        op_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [ADDR_W-1:0] rd_addr1_reg;
  logic [ADDR_W-1:0] rd_addr2_reg;
  logic [DATA_W-1:0] opa_reg;
  logic [DATA_W-1:0] opb_reg;
  logic [DATA_W-1:0] result_reg;
  logic              carry_reg;
  logic              zero_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] and_bits;
  logic [DATA_W-1:0] or_bits;
  logic [DATA_W-1:0] xor_bits;
  logic [DATA_W-1:0] result_next;
  logic              carry_next;
  logic              zero_next;

  assign sum_ext  = {1'b0, opa_reg} + {1'b0, opb_reg};
  // Extended subtraction: the top bit is the unsigned borrow (opa < opb).
  assign diff_ext = {1'b0, opa_reg} - {1'b0, opb_reg};

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_logic_bits
      assign and_bits[gi] = opa_reg[gi] & opb_reg[gi];
      assign or_bits[gi]  = opa_reg[gi] | opb_reg[gi];
      assign xor_bits[gi] = opa_reg[gi] ^ opb_reg[gi];
    end
  endgenerate

  always_comb begin
    result_next = '0;
    carry_next  = 1'b0;
    case (op_reg)
      OP_ADD: begin
        result_next = sum_ext[DATA_W-1:0];
        carry_next  = sum_ext[DATA_W];
      end
      OP_SUB: begin
        result_next = diff_ext[DATA_W-1:0];
        carry_next  = diff_ext[DATA_W];
      end
      OP_AND: result_next = and_bits;
      OP_OR:  result_next = or_bits;
      OP_XOR: result_next = xor_bits;
      OP_LDI: result_next = imm_reg;
      OP_MOV: result_next = opa_reg;
      OP_RD:  result_next = opa_reg;
      default: result_next = '0;
    endcase
    zero_next = (result_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      dst_reg      <= '0;
      imm_reg      <= '0;
      rd_addr1_reg <= '0;
      rd_addr2_reg <= '0;
      opa_reg      <= '0;
      opb_reg      <= '0;
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      zero_reg     <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            op_reg       <= cmd_op;
            dst_reg      <= cmd_dst;
            imm_reg      <= cmd_imm;
            rd_addr1_reg <= cmd_src1;
            rd_addr2_reg <= cmd_src2;
            state_reg    <= READ;
          end
        end
        READ: begin
          opa_reg   <= rd_data1;
          opb_reg   <= rd_data2;
          state_reg <= EXEC;
        end
        EXEC: begin
          result_reg <= result_next;
          carry_reg  <= carry_next;
          zero_reg   <= zero_next;
          if (op_reg == OP_RD) begin
            state_reg <= RESP;
          end else begin
            // Write port values are loaded here so they are valid for the whole WRITE cycle.
            wr_addr_reg <= dst_reg;
            wr_data_reg <= result_next;
            state_reg   <= WRITE;
          end
        end
        WRITE: state_reg <= RESP;
        RESP: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign wr_en     = (state_reg == WRITE);
  assign rsp_valid = (state_reg == RESP);
  assign rd_addr1  = rd_addr1_reg;
  assign rd_addr2  = rd_addr2_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign rsp_data  = result_reg;
  assign rsp_carry = carry_reg;
  assign rsp_zero  = zero_reg;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 8x8 register file model.
module tb_regfile_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_src1;
  logic [2:0] cmd_src2;
  logic [7:0] cmd_imm;
  logic [2:0] rd_addr1;
  logic [2:0] rd_addr2;
  logic [7:0] rd_data1;
  logic [7:0] rd_data2;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       busy;

  logic [7:0] rf [0:7];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_imm(cmd_imm),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Register file: combinational reads, write on the rising edge, never reset.
  assign rd_data1 = rf[rd_addr1];
  assign rd_data2 = rf[rd_addr2];
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  typedef struct {
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [7:0] imm;
    logic [7:0] e_data;
    logic       e_c;
    logic       e_z;
    logic       e_wr;
  } vec_t;

  vec_t vecs [0:13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_op   = v.op;
    cmd_dst  = v.dst;
    cmd_src1 = v.s1;
    cmd_src2 = v.s2;
    cmd_imm  = v.imm;
  endtask

  // One full command: accept, track write and response timing, complete handshake.
  task automatic run_cmd(input vec_t v, input int tag);
    int wr_j, rsp_j, nwr;
    logic [2:0] wa;
    logic [7:0] wd;
    wr_j = 0; rsp_j = 0; nwr = 0; wa = '0; wd = '0;
    @(negedge clk);
    chk($sformatf("v%0d cmd_ready", tag), cmd_ready, 1);
    drive_cmd(v);
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int j = 1; j <= 10 && rsp_j == 0; j++) begin
      @(negedge clk);
      if (j == 1) chk($sformatf("v%0d busy", tag), busy, 1);
      if (wr_en) begin
        nwr++;
        wr_j = j;
        wa = wr_addr;
        wd = wr_data;
      end
      if (rsp_valid) begin
        rsp_j = j;
        chk($sformatf("v%0d rsp_data", tag), rsp_data, v.e_data);
        chk($sformatf("v%0d rsp_carry", tag), rsp_carry, v.e_c);
        chk($sformatf("v%0d rsp_zero", tag), rsp_zero, v.e_z);
      end
    end
    chk($sformatf("v%0d rsp_latency", tag), rsp_j, v.e_wr ? 4 : 3);
    chk($sformatf("v%0d wr_count", tag), nwr, v.e_wr ? 1 : 0);
    if (v.e_wr) begin
      chk($sformatf("v%0d wr_latency", tag), wr_j, 3);
      chk($sformatf("v%0d wr_addr", tag), wa, v.dst);
      chk($sformatf("v%0d wr_data", tag), wd, v.e_data);
    end
    $display("cmd %0d op=%0d dst=%0d s1=%0d s2=%0d -> rsp=%0d c=%0d z=%0d wr=%0d", tag,
             v.op, v.dst, v.s1, v.s2, rsp_data, rsp_carry, rsp_zero, nwr);
    @(posedge clk);
  endtask

  initial begin
    vec_t v;
    int got;
    for (int i = 0; i < 8; i++) rf[i] = 8'd0;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_dst = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_imm = '0;

    //               op     dst   s1    s2    imm     data  c  z  wr
    vecs[0]  = '{3'd5, 3'd1, 3'd0, 3'd0, 8'd200, 8'd200, 0, 0, 1}; // LDI r1=200
    vecs[1]  = '{3'd5, 3'd2, 3'd0, 3'd0, 8'd100, 8'd100, 0, 0, 1}; // LDI r2=100
    vecs[2]  = '{3'd0, 3'd3, 3'd1, 3'd2, 8'hA5,  8'd44,  1, 0, 1}; // ADD 200+100
    vecs[3]  = '{3'd7, 3'd0, 3'd3, 3'd6, 8'hA5,  8'd44,  0, 0, 0}; // RD r3
    vecs[4]  = '{3'd1, 3'd4, 3'd2, 3'd1, 8'hA5,  8'd156, 1, 0, 1}; // SUB 100-200
    vecs[5]  = '{3'd4, 3'd5, 3'd1, 3'd1, 8'hA5,  8'd0,   0, 1, 1}; // XOR r1^r1
    vecs[6]  = '{3'd2, 3'd6, 3'd1, 3'd2, 8'hA5,  8'd64,  0, 0, 1}; // AND
    vecs[7]  = '{3'd3, 3'd7, 3'd1, 3'd2, 8'hA5,  8'd236, 0, 0, 1}; // OR
    vecs[8]  = '{3'd6, 3'd0, 3'd2, 3'd5, 8'hA5,  8'd100, 0, 0, 1}; // MOV r0=r2
    vecs[9]  = '{3'd1, 3'd0, 3'd1, 3'd2, 8'hA5,  8'd100, 0, 0, 1}; // SUB 200-100
    vecs[10] = '{3'd7, 3'd0, 3'd7, 3'd0, 8'hA5,  8'd236, 0, 0, 0}; // RD r7
    vecs[11] = '{3'd5, 3'd6, 3'd3, 3'd3, 8'd0,   8'd0,   0, 1, 1}; // LDI r6=0
    vecs[12] = '{3'd0, 3'd1, 3'd6, 3'd6, 8'hA5,  8'd0,   0, 1, 1}; // ADD 0+0
    vecs[13] = '{3'd7, 3'd2, 3'd5, 3'd4, 8'hA5,  8'd0,   0, 1, 0}; // RD r5

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_cmd(vecs[i], i);

    // Backpressure: response held while cmd_valid presents a competing LDI r3=9.
    @(negedge clk);
    v = '{3'd7, 3'd0, 3'd3, 3'd0, 8'd0, 8'd44, 0, 0, 0};
    drive_cmd(v);
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 begin cmd_op = 3'd5; cmd_dst = 3'd3; cmd_imm = 8'd9; end
    got = 0;
    for (int j = 0; j < 10 && got == 0; j++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    chk("bp rsp_seen", got, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d rsp_valid", k), rsp_valid, 1);
      chk($sformatf("bp%0d rsp_data", k), rsp_data, 44);
      chk($sformatf("bp%0d cmd_ready", k), cmd_ready, 0);
      chk($sformatf("bp%0d wr_en", k), wr_en, 0);
      $display("backpressure cycle %0d rsp_valid=%0d rsp_data=%0d", k, rsp_valid, rsp_data);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp rsp_valid_after", rsp_valid, 0);
    chk("bp cmd_ready_after", cmd_ready, 1);
    run_cmd(v, 100); // r3 still 44: the LDI was never accepted

    // Reset during EXEC of ADD r3=r1+r2 (would give 100): write must not happen.
    @(negedge clk);
    v = '{3'd0, 3'd3, 3'd1, 3'd2, 8'd0, 8'd100, 0, 0, 1};
    drive_cmd(v);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("rx read wr_en", wr_en, 0);
    @(negedge clk);
    chk("rx exec busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rx cmd_ready", cmd_ready, 1);
    chk("rx busy", busy, 0);
    chk("rx wr_en", wr_en, 0);
    chk("rx rsp_valid", rsp_valid, 0);
    chk("rx rd_addr1", rd_addr1, 0);
    chk("rx rd_addr2", rd_addr2, 0);
    chk("rx wr_addr", wr_addr, 0);
    chk("rx wr_data", wr_data, 0);
    chk("rx rsp_data", rsp_data, 0);
    chk("rx rsp_carry", rsp_carry, 0);
    chk("rx rsp_zero", rsp_zero, 0);
    $display("reset in EXEC: busy=%0d wr_en=%0d rsp_valid=%0d", busy, wr_en, rsp_valid);
    reset = 1'b0;
    v = '{3'd7, 3'd0, 3'd3, 3'd0, 8'd0, 8'd44, 0, 0, 0};
    run_cmd(v, 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
